uart_rx_os: RTL and testbench

UART_RX_OS -- requirements
Module: uart_rx_os

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_cnt.sv | 33 +++
 rtl/uart_rx_os.sv | 159 +++++++++++++++
 tb/tb_uart_rx_os.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default
// frame geometry.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Baud counter: counts up from 0 and pulses tick on the last cycle of a half
// or full bit period, then restarts from 0.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic half,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = !clear && (cnt_q == (half ? HALF_LAST : FULL_LAST));

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with mid-bit sampling and break handling.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_W       = UART_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  input  logic              rx_en,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);

  localparam int IW = $clog2(DATA_W + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

  uart_state_e       state_q, state_d;
  logic              rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0] shift_q, shift_d, data_out_q, data_out_d;
  logic              data_valid_q, data_valid_d, frame_err_q, frame_err_d;
  logic              cnt_clear, cnt_half, cnt_tick;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q, par_bad_d, parity_err_q, parity_err_d;
`endif

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .clear (cnt_clear),
    .half  (cnt_half),
    .tick  (cnt_tick)
  );

  always_comb begin
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    cnt_clear    = 1'b0;
    cnt_half     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_clear = 1'b1;
        bit_idx_d = '0;
        if (rx_en && !rx_s_q) state_d = S_START;
      end
      S_START: begin
        cnt_half = 1'b1;
        // A line that is high again at mid-start was only a glitch
        if (cnt_tick) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (cnt_tick) begin
          shift_d = {rx_s_q, shift_q[DATA_W-1:1]};
          if (bit_idx_q == LAST_IDX) begin
            bit_idx_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d   = S_PARITY;
`else
            state_d   = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_tick) begin
          par_bad_d = (^shift_q) ^ rx_s_q;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_tick) begin
          if (!rx_s_q) begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end else begin
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              data_out_d   = shift_q;
              data_valid_d = 1'b1;
            end
`else
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
`endif
            state_d = S_IDLE;
          end
        end
      end
      S_BREAK: begin
        cnt_clear = 1'b1;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: serial frames are generated bit by bit and
// the output pulses are compared against a per-frame outcome model.
module tb_uart_rx_os;

  localparam int CPB = 16;
  localparam int DW  = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
  localparam int PRE_STOP_BITS = DW + 2;
`else
  localparam bit PAR_EN = 1'b0;
  localparam int PRE_STOP_BITS = DW + 1;
`endif
  // Two synchronizer cycles, half a start bit, then every bit before the stop bit
  localparam int PULSE_LAT = 2 + CPB / 2 + PRE_STOP_BITS * CPB;

  // kind: 0 = data_valid, 1 = frame_err, 2 = parity_err
  typedef struct {
    int          kind;
    logic [DW-1:0] data;
    int          cyc;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx = 1'b1;
  logic          rx_en = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid, frame_err, parity_err, busy;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  bit            mon_on = 1'b0;
  ev_t           got_q[$];
  ev_t           exp_q[$];
  logic [DW-1:0] model_data = '0;

  uart_rx_os #(.CLKS_PER_BIT(CPB), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_en      (rx_en),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every high output pulse becomes one event, so overlapping or stretched
  // pulses show up as extra events
  always @(negedge clk) begin
    if (mon_on) begin
      if (data_valid) got_q.push_back('{0, data_out, cyc});
      if (frame_err)  got_q.push_back('{1, data_out, cyc});
      if (parity_err) got_q.push_back('{2, data_out, cyc});
    end
  end

  // Outcome of one frame from its contents alone
  function automatic void predict(input logic [DW-1:0] d, input logic stop_bit, input logic par_ok);
    ev_t e;
    e.data = d;
    e.cyc  = 0;
    if (!stop_bit) begin
      e.kind = 1;
    end else if (PAR_EN && !par_ok) begin
      e.kind = 2;
    end else begin
      e.kind = 0;
      model_data = d;
    end
    exp_q.push_back(e);
  endfunction

  function automatic void clear_events();
    got_q.delete();
    exp_q.delete();
  endfunction

  // Drives start, data LSB first, optional parity and stop, then extra low bits
  // when the stop bit is low; rx_en may be dropped at a chosen bit index
  task automatic send_frame(input logic [DW-1:0] d, input logic stop_bit, input logic par_ok,
                            input int hold_low_bits, input int en_drop_bit, output int start_cyc);
    logic seq[$];
    seq.push_back(1'b0);
    for (int i = 0; i < DW; i++) seq.push_back(d[i]);
    if (PAR_EN) seq.push_back((^d) ^ !par_ok);
    seq.push_back(stop_bit);
    start_cyc = cyc + 1;
    foreach (seq[i]) begin
      if (i == en_drop_bit) rx_en = 1'b0;
      rx = seq[i];
      repeat (CPB) @(negedge clk);
    end
    if (!stop_bit) repeat (hold_low_bits * CPB) @(negedge clk);
    if (en_drop_bit >= 0) rx_en = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rx = 1'b1; rx_en = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (data_out !== '0) begin bad++; $display("[TB] FAIL reset_data_out: got=%h want=00", data_out); end
    total++; if (data_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_data_valid: got=%b want=0", data_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_err: got=%b want=0", frame_err); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_parity_err: got=%b want=0", parity_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got=%b want=0", busy); end
    rst = 1'b1;
    mon_on = 1'b1;
    model_data = '0;
    repeat (2 * CPB) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle_busy: got=%b want=0", busy); end
  endtask

  task automatic test_single();
    int s;
    clear_events();
    send_frame(8'hA5, 1'b1, 1'b1, 0, -1, s);
    predict(8'hA5, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL single_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == 0 && got_q[i].data !== exp_q[i].data)) begin
        bad++; $display("[TB] FAIL single_event%0d: got kind=%0d data=%h want kind=%0d data=%h", i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
      total++;
      if (got_q[i].cyc !== s + PULSE_LAT) begin
        bad++; $display("[TB] FAIL single_timing: got cycle=%0d want=%0d", got_q[i].cyc, s + PULSE_LAT);
      end
    end
    total++; if (data_out !== model_data) begin bad++; $display("[TB] FAIL single_data_out: got=%h want=%h", data_out, model_data); end
  endtask

  task automatic test_glitch();
    clear_events();
    rx = 1'b0;
    repeat (5) @(negedge clk);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL glitch_busy_high: got=%b want=1", busy); end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL glitch_busy_low: got=%b want=0", busy); end
    total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL glitch_pulses: got=%0d want=0", got_q.size()); end
  endtask

  task automatic test_break();
    int s;
    clear_events();
    send_frame(8'h3C, 1'b0, 1'b1, 39, -1, s);
    predict(8'h3C, 1'b0, 1'b1);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL break_busy: got=%b want=1", busy); end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL break_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind) begin
        bad++; $display("[TB] FAIL break_event%0d: got kind=%0d want kind=%0d", i, got_q[i].kind, exp_q[i].kind);
      end
    end
    total++; if (data_out !== model_data) begin bad++; $display("[TB] FAIL break_data_out: got=%h want=%h", data_out, model_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL break_release_busy: got=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    int s;
    vals = '{8'h00, 8'hFF, 8'h55};
    clear_events();
    foreach (vals[i]) begin
      send_frame(vals[i], 1'b1, 1'b1, 0, -1, s);
      predict(vals[i], 1'b1, 1'b1);
    end
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL b2b_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == 0 && got_q[i].data !== exp_q[i].data)) begin
        bad++; $display("[TB] FAIL b2b_event%0d: got kind=%0d data=%h want kind=%0d data=%h", i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++; if (data_out !== model_data) begin bad++; $display("[TB] FAIL b2b_data_out: got=%h want=%h", data_out, model_data); end
  endtask

  task automatic test_rx_en();
    int s;
    clear_events();
    rx_en = 1'b0;
    send_frame(8'h00, 1'b1, 1'b1, 0, -1, s);
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != 0) begin bad++; $display("[TB] FAIL rx_en_off_pulses: got=%0d want=0", got_q.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rx_en_off_busy: got=%b want=0", busy); end
    rx_en = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic [DW-1:0] d;
    int s;
    d = 8'h81;
    clear_events();
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = d[4];
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b0; rx = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (data_out !== '0) begin bad++; $display("[TB] FAIL abort_data_out: got=%h want=00", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL abort_busy: got=%b want=0", busy); end
    rst = 1'b1;
    model_data = '0;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h42, 1'b1, 1'b1, 0, -1, s);
    predict(8'h42, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL abort_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || got_q[i].data !== exp_q[i].data) begin
        bad++; $display("[TB] FAIL abort_event%0d: got kind=%0d data=%h want kind=%0d data=%h", i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++; if (data_out !== 8'h42) begin bad++; $display("[TB] FAIL abort_data_after: got=%h want=42", data_out); end
  endtask

  task automatic test_random();
    logic [DW-1:0] d;
    logic stop_bit, par_ok;
    int s, gap, hold, drop;
    clear_events();
    for (int n = 0; n < 20; n++) begin
      d        = DW'($urandom);
      stop_bit = ($urandom_range(0, 5) != 0);
      par_ok   = ($urandom_range(0, 3) != 0);
      hold     = $urandom_range(0, 3);
      drop     = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DW)) : -1;
      gap      = stop_bit ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(d, stop_bit, par_ok, hold, drop, s);
      predict(d, stop_bit, par_ok);
      rx = 1'b1;
      repeat (gap * CPB) @(negedge clk);
    end
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL random_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == 0 && got_q[i].data !== exp_q[i].data)) begin
        bad++; $display("[TB] FAIL random_event%0d: got kind=%0d data=%h want kind=%0d data=%h", i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++; if (data_out !== model_data) begin bad++; $display("[TB] FAIL random_data_out: got=%h want=%h", data_out, model_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    int s;
    clear_events();
    send_frame(8'h07, 1'b1, 1'b0, 0, -1, s);
    predict(8'h07, 1'b1, 1'b0);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    total++; if (data_out !== model_data) begin bad++; $display("[TB] FAIL parity_bad_data_out: got=%h want=%h", data_out, model_data); end
    send_frame(8'h07, 1'b1, 1'b1, 0, -1, s);
    predict(8'h07, 1'b1, 1'b1);
    repeat (2 * CPB) @(negedge clk);
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("[TB] FAIL parity_count: got=%0d want=%0d", got_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i].kind !== exp_q[i].kind || (exp_q[i].kind == 0 && got_q[i].data !== exp_q[i].data)) begin
        bad++; $display("[TB] FAIL parity_event%0d: got kind=%0d data=%h want kind=%0d data=%h", i, got_q[i].kind, got_q[i].data, exp_q[i].kind, exp_q[i].data);
      end
    end
    total++; if (data_out !== 8'h07) begin bad++; $display("[TB] FAIL parity_good_data_out: got=%h want=07", data_out); end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_break();
    test_back_to_back();
    test_rx_en();
    test_reset_abort();
    test_random();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
